imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter DATA_W, default 64, output immediate width; legal values 32 or 64.
REQ-002 Parameter BR_SHIFT, default 0; when 1, CB/B offsets are multiplied by 4 (shift left 2) before output.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  instruction word and format are valid this cycle.
REQ-006 in_ready  out  1  block accepts input this cycle.
REQ-007 instr  in  32  LEGv8 instruction word.
REQ-008 fmt  in  3  format code: 0 D, 1 CB, 2 B, 3 I, 4 IW; 5-7 illegal.
REQ-009 flush  in  1  discard all in-flight entries.
REQ-010 out_valid  out  1  out_imm/out_err are valid.
REQ-011 out_ready  in  1  consumer accepts output.
REQ-012 out_imm  out  DATA_W  extended immediate.
REQ-013 out_err  out  1  illegal format or IW shift beyond DATA_W.

Function
REQ-014 Two-stage pipeline: S1 registers extracted raw field, fmt and shift amount; S2 registers the extended result; accept-to-output latency exactly 2 cycles with no stall.
REQ-015 Transfer at a port occurs only when valid and ready are both high in the same cycle.
REQ-016 Each stage advances when its downstream slot is empty or being drained the same cycle; in_ready = !S1_valid || S1 advancing (no combinational path from in_valid to in_ready).
REQ-017 Full throughput: one instruction per cycle while out_ready is held high.
REQ-018 Held output (out_valid=1, out_ready=0) keeps out_imm/out_err stable until accepted.
REQ-019 D: sign-extend instr[20:12] (9 bits).
REQ-020 CB: sign-extend instr[23:5] (19 bits), then shift by BR_SHIFT.
REQ-021 B: sign-extend instr[25:0] (26 bits), then shift by BR_SHIFT.
REQ-022 I: zero-extend instr[21:10] (12 bits).
REQ-023 IW: zero-extend instr[20:5] (16 bits), shifted left by 16*instr[22:21].
REQ-024 IW with DATA_W=32 and instr[22:21]>=2: out_err=1, out_imm=0.
REQ-025 Illegal fmt: out_err=1, out_imm=0; the entry still flows through the pipeline and is consumed normally.
REQ-026 flush=1: S1 and S2 valid bits cleared next edge; an input presented in the flush cycle is dropped; in_ready stays 1 during flush.
REQ-027 Flush overrides simultaneous input acceptance and output stall.

Reset
REQ-028 On rst_n low: S1/S2 valid=0, out_valid=0, out_imm=0, out_err=0, in_ready=1, immediately (asynchronous).
REQ-029 Reset release mid-transaction resumes from empty; no pre-reset entry reappears.

Structure
REQ-030 Shared package holds fmt encodings (FMT_D..FMT_IW), field bit positions and widths.
REQ-031 One sub-module, imm_extract (combinational field select + extend per fmt), instantiated between S1 and S2.

Verification
REQ-032 DATA_W=64, fmt=D, instr[20:12]=9'h1FF, out_ready=1 -> out_imm=64'hFFFF_FFFF_FFFF_FFFF, 2 cycles after acceptance.
REQ-033 BR_SHIFT=1, fmt=B, instr[25:0]=26'h2000000 -> out_imm=64'hFFFF_FFFF_F800_0000.
REQ-034 fmt=IW, instr[20:5]=16'hBEEF, hw=3 -> out_imm=64'hBEEF_0000_0000_0000; DATA_W=32 same stimulus -> out_err=1, out_imm=0.
REQ-035 Back-to-back 8 inputs with out_ready low for 3 cycles mid-stream -> all 8 outputs in order, none lost or duplicated, in_ready low only while both stages are full.
REQ-036 Two entries in flight, flush=1 concurrent with in_valid=1 -> out_valid=0 next cycle, no outputs from those three entries.
REQ-037 rst_n asserted with full pipeline -> out_valid=0 asynchronously, first post-reset input appears 2 cycles after acceptance.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the LEGv8 immediate generator pipeline.
// Covers the format encodings and the instruction field positions/widths.
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        FMT_D  = 3'd0,
        FMT_CB = 3'd1,
        FMT_B  = 3'd2,
        FMT_I  = 3'd3,
        FMT_IW = 3'd4
    } fmt_e;

    // Bits [25:0] hold every immediate field, so S1 only keeps that slice.
    localparam int RAW_W  = 26;

    localparam int D_LSB  = 12;
    localparam int D_W    = 9;
    localparam int CB_LSB = 5;
    localparam int CB_W   = 19;
    localparam int B_LSB  = 0;
    localparam int B_W    = 26;
    localparam int I_LSB  = 10;
    localparam int I_W    = 12;
    localparam int IW_LSB = 5;
    localparam int IW_W   = 16;
    localparam int HW_LSB = 21;
    localparam int HW_W   = 2;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational field select and extension for every LEGv8 immediate format.
// Sits between the S1 and S2 registers of imm_gen_pipe.
module imm_extract
    import imm_gen_pipe_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int BR_SHIFT = 0
) (
    input  logic [RAW_W-1:0]  raw,
    input  logic [2:0]        fmt,
    input  logic [HW_W-1:0]   hw,
    output logic [DATA_W-1:0] imm,
    output logic              err
);

    localparam int BR_SH = (BR_SHIFT != 0) ? 2 : 0;

    logic [DATA_W-1:0] d_ext;
    logic [DATA_W-1:0] cb_ext;
    logic [DATA_W-1:0] b_ext;
    logic [DATA_W-1:0] i_ext;
    logic [DATA_W-1:0] iw_ext;

    assign d_ext  = {{(DATA_W-D_W){raw[D_LSB+D_W-1]}}, raw[D_LSB +: D_W]};
    assign cb_ext = {{(DATA_W-CB_W){raw[CB_LSB+CB_W-1]}}, raw[CB_LSB +: CB_W]};
    assign b_ext  = {{(DATA_W-B_W){raw[B_LSB+B_W-1]}}, raw[B_LSB +: B_W]};
    assign i_ext  = {{(DATA_W-I_W){1'b0}}, raw[I_LSB +: I_W]};
    assign iw_ext = {{(DATA_W-IW_W){1'b0}}, raw[IW_LSB +: IW_W]} << {hw, 4'b0000};

    // A 32-bit result cannot hold halfword positions 2 and 3.
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (fmt)
            FMT_D:  imm = d_ext;
            FMT_CB: imm = cb_ext << BR_SH;
            FMT_B:  imm = b_ext << BR_SH;
            FMT_I:  imm = i_ext;
            FMT_IW: begin
                if (DATA_W == 32 && hw[1]) begin
                    err = 1'b1;
                end else begin
                    imm = iw_ext;
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator: S1 holds the raw fields,
// S2 holds the extended immediate presented to the consumer.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int BR_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [2:0]        fmt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_err
);

    logic              s1_valid;
    logic [RAW_W-1:0]  s1_raw;
    logic [2:0]        s1_fmt;
    logic [HW_W-1:0]   s1_hw;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_imm;
    logic              s2_err;

    logic              s2_adv;
    logic [DATA_W-1:0] ext_imm;
    logic              ext_err;
    logic              unused_instr_hi;

    assign unused_instr_hi = ^instr[31:26];

    // S2 can take a new entry when empty or when its current entry leaves.
    assign s2_adv   = !s2_valid || out_ready;
    assign in_ready = flush || !s1_valid || s2_adv;

    assign out_valid = s2_valid;
    assign out_imm   = s2_imm;
    assign out_err   = s2_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
            s1_fmt   <= '0;
            s1_hw    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_raw <= instr[RAW_W-1:0];
                s1_fmt <= fmt;
                s1_hw  <= instr[HW_LSB +: HW_W];
            end
        end
    end

    imm_extract #(
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_extract (
        .raw (s1_raw),
        .fmt (s1_fmt),
        .hw  (s1_hw),
        .imm (ext_imm),
        .err (ext_err)
    );

    // Result registers only move on advance, so a stalled output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_imm   <= '0;
            s2_err   <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_imm <= ext_imm;
                s2_err <= ext_err;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 64-bit/BR_SHIFT=1 instance and a
// 32-bit/BR_SHIFT=0 instance driven by the same stimulus.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_imm;
    logic        out_err;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] out_imm32;
    logic        out_err32;

    int checks = 0;
    int errors = 0;

    imm_gen_pipe #(.DATA_W(64), .BR_SHIFT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .fmt       (fmt),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_err   (out_err)
    );

    imm_gen_pipe #(.DATA_W(32), .BR_SHIFT(0)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .instr     (instr),
        .fmt       (fmt),
        .flush     (flush),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .out_imm   (out_imm32),
        .out_err   (out_err32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] f, input logic [31:0] i);
        in_valid = v;
        fmt      = f;
        instr    = i;
    endtask

    // One isolated transaction: accept, check 2-cycle latency, then drain.
    task automatic runOne(input string tag, input logic [2:0] f, input logic [31:0] i,
                          input logic [63:0] e64, input logic e64err,
                          input logic [31:0] e32, input logic e32err);
        out_ready = 1'b1;
        applyStimulus(1'b1, f, i);
        #1;
        checkOutput({tag, "_rdy"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_rdy32"}, 64'(in_ready32), 64'd1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 3'd0, 32'd0);
        checkOutput({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        checkOutput({tag, "_vld"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_imm"}, out_imm, e64);
        checkOutput({tag, "_err"}, 64'(out_err), 64'(e64err));
        checkOutput({tag, "_vld32"}, 64'(out_valid32), 64'd1);
        checkOutput({tag, "_imm32"}, 64'(out_imm32), 64'(e32));
        checkOutput({tag, "_err32"}, 64'(out_err32), 64'(e32err));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sent;
        int rcv;
        int lowCnt;
        int lastOut;
        int seen;
        logic [63:0] ev;

        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'd0);
        #2;
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_imm", out_imm, 64'd0);
        checkOutput("rst_err", 64'(out_err), 64'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;

        runOne("d_neg", 3'd0, 32'h001F_F000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);
        runOne("d_pos", 3'd0, 32'h000A_B000, 64'h0000_0000_0000_00AB, 1'b0, 32'h0000_00AB, 1'b0);
        runOne("cb_neg", 3'd1, 32'h0080_0020, 64'hFFFF_FFFF_FFF0_0004, 1'b0, 32'hFFFC_0001, 1'b0);
        runOne("b_neg", 3'd2, 32'h0200_0000, 64'hFFFF_FFFF_F800_0000, 1'b0, 32'hFE00_0000, 1'b0);
        runOne("b_pos", 3'd2, 32'h0000_0123, 64'h0000_0000_0000_048C, 1'b0, 32'h0000_0123, 1'b0);
        runOne("i_max", 3'd3, 32'h007F_FC00, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0);
        runOne("iw_hw3", 3'd4, 32'h0077_DDE0, 64'hBEEF_0000_0000_0000, 1'b0, 32'h0000_0000, 1'b1);
        runOne("iw_hw1", 3'd4, 32'h0022_4680, 64'h0000_0000_1234_0000, 1'b0, 32'h1234_0000, 1'b0);
        runOne("ill5", 3'd5, 32'hFFFF_FFFF, 64'd0, 1'b1, 32'd0, 1'b1);
        runOne("ill7", 3'd7, 32'h0000_0000, 64'd0, 1'b1, 32'd0, 1'b1);

        // Eight back-to-back B entries with a 3-cycle consumer stall.
        sent = 0; rcv = 0; lowCnt = 0; lastOut = -1;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 4 && c <= 6);
            applyStimulus(sent < 8, 3'd2, 32'(sent + 1));
            #1;
            if (!in_ready) lowCnt++;
            if (out_valid) begin
                ev = 64'(rcv + 1);
                ev = ev << 2;
                checkOutput("stream_imm", out_imm, ev);
                if (out_ready) begin
                    rcv++;
                    lastOut = c;
                end
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 3'd0, 32'd0);
        checkOutput("stream_sent", 64'(sent), 64'd8);
        checkOutput("stream_rcv", 64'(rcv), 64'd8);
        checkOutput("stream_rdy_low", 64'(lowCnt), 64'd3);
        checkOutput("stream_last", 64'(lastOut), 64'd12);

        // Flush with two entries in flight, a stalled output and a new input.
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'd0, 32'h0000_1000);
        @(posedge clk); #1;
        applyStimulus(1'b1, 3'd0, 32'h0000_2000);
        @(posedge clk); #1;
        applyStimulus(1'b1, 3'd0, 32'h0000_3000);
        flush = 1'b1;
        #1;
        checkOutput("flush_pre_vld", 64'(out_valid), 64'd1);
        checkOutput("flush_rdy", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0);
        checkOutput("flush_vld", 64'(out_valid), 64'd0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checkOutput("flush_leak", 64'(seen), 64'd0);
        runOne("post_flush", 3'd3, 32'h0000_0400, 64'd1, 1'b0, 32'd1, 1'b0);

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'd0, 32'h0000_1000);
        @(posedge clk); #1;
        applyStimulus(1'b1, 3'd0, 32'h0000_2000);
        @(posedge clk); #1;
        applyStimulus(1'b0, 3'd0, 32'd0);
        checkOutput("arst_pre_vld", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_vld", 64'(out_valid), 64'd0);
        checkOutput("arst_imm", out_imm, 64'd0);
        checkOutput("arst_rdy", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checkOutput("arst_leak", 64'(seen), 64'd0);
        runOne("post_rst", 3'd0, 32'h0010_0000, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 32'hFFFF_FF00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
